// File: rtl/pixel_write_buffer.sv
// pixel_write_buffer
// Decouples draw_line pixel writes from the display SRAM write port.
// Pixels are queued as {linear address, value}; each granted cycle
// drains one entry into registered SRAM write outputs.
// Optional build macro PIXEL_WRITE_CLIP_EN: discard pushes outside
// H_RES x V_RES and flag each one with a one-cycle clip_drop pulse.
module pixel_write_buffer #(
   parameter int DEPTH = 16,
   parameter int H_RES = 160,
   parameter int V_RES = 120
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        wr_valid,
   input  logic [7:0]  write_x_pos,
   input  logic [6:0]  write_y_pos,
   input  logic        pixel_value,
   input  logic        sram_wr_grant,
   input  logic        clear_overflow,
   output logic        sram_we,
   output logic [14:0] sram_addr,
   output logic        sram_wdata,
   output logic [6:0]  fifo_count,
   output logic        fifo_full,
   output logic        fifo_empty,
   output logic        overflow,
   output logic        clip_drop,
   output logic        idle
);

   localparam int          AW      = $clog2(DEPTH);
   localparam logic [6:0]  DEPTH_C = 7'(DEPTH);
   localparam logic [14:0] H_RES_C = 15'(H_RES);

   // Linear address y*H_RES+x built as a constant shift-add sum, so only
   // adders sit on the push side and the pop side is a plain register read.
   function automatic logic [14:0] f_lin_addr(input logic [6:0] y, input logic [7:0] x);
      logic [14:0] acc;
      acc = {7'd0, x};
      for (int b = 0; b < 15; b++) begin
         if (H_RES_C[b]) acc = acc + ({8'd0, y} << b);
      end
      return acc;
   endfunction

   logic [14:0]   r_mem_addr [DEPTH];
   logic          r_mem_val  [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [6:0]    r_count;
   logic          r_sram_we;
   logic [14:0]   r_sram_addr;
   logic          r_sram_wdata;
   logic          r_overflow;

   logic          w_in_range;
   logic          w_push_req;
   logic          w_push;
   logic          w_pop;
   logic          w_ovf_evt;
   logic [14:0]   w_push_addr;

`ifdef PIXEL_WRITE_CLIP_EN
   assign w_in_range = (int'(write_x_pos) < H_RES) && (int'(write_y_pos) < V_RES);
`else
   assign w_in_range = 1'b1;
`endif

   // Pop needs a grant and a stored entry; there is no bypass from an empty FIFO.
   assign w_pop       = sram_wr_grant && (r_count != 7'd0);
   assign w_push_req  = wr_valid && w_in_range;
   // A full FIFO still accepts when the head leaves on the same edge.
   assign w_push      = w_push_req && ((r_count != DEPTH_C) || w_pop);
   assign w_ovf_evt   = w_push_req && !w_push;
   assign w_push_addr = f_lin_addr(write_y_pos, write_x_pos);

   // Entry storage: written on push only, never reset.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem_addr[r_wr_ptr] <= w_push_addr;
         r_mem_val[r_wr_ptr]  <= pixel_value;
      end
   end

   // Pointers wrap naturally at DEPTH (power of two); count disambiguates full/empty.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= 7'd0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 7'd1;
            2'b01:   r_count <= r_count - 7'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   // SRAM write outputs: strobe for one cycle per pop, address/data hold otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sram_we    <= 1'b0;
         r_sram_addr  <= 15'd0;
         r_sram_wdata <= 1'b0;
      end else begin
         r_sram_we <= w_pop;
         if (w_pop) begin
            r_sram_addr  <= r_mem_addr[r_rd_ptr];
            r_sram_wdata <= r_mem_val[r_rd_ptr];
         end
      end
   end

   // Sticky overflow; a drop on the same edge as a clear keeps it set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)              r_overflow <= 1'b0;
      else if (w_ovf_evt)      r_overflow <= 1'b1;
      else if (clear_overflow) r_overflow <= 1'b0;
   end

`ifdef PIXEL_WRITE_CLIP_EN
   logic r_clip_drop;

   // One-cycle pulse for every out-of-range pixel that was discarded.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_clip_drop <= 1'b0;
      else        r_clip_drop <= wr_valid && !w_in_range;
   end

   assign clip_drop = r_clip_drop;
`else
   assign clip_drop = 1'b0;
`endif

   assign sram_we    = r_sram_we;
   assign sram_addr  = r_sram_addr;
   assign sram_wdata = r_sram_wdata;
   assign fifo_count = r_count;
   assign fifo_full  = (r_count == DEPTH_C);
   assign fifo_empty = (r_count == 7'd0);
   assign overflow   = r_overflow;
   assign idle       = (r_count == 7'd0) && !r_sram_we;

endmodule

// File: tb/tb_pixel_write_buffer.sv
// Bench for pixel_write_buffer: directed scenarios plus a randomized run,
// every cycle compared against a queue-based model of the buffer.
module tb_pixel_write_buffer;

  localparam int DEPTH = 16;
  localparam int H_RES = 160;
  localparam int V_RES = 120;
`ifdef PIXEL_WRITE_CLIP_EN
  localparam bit CLIP = 1'b1;
`else
  localparam bit CLIP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_valid = 1'b0;
  logic [7:0]  write_x_pos = 8'd0;
  logic [6:0]  write_y_pos = 7'd0;
  logic        pixel_value = 1'b0;
  logic        sram_wr_grant = 1'b0;
  logic        clear_overflow = 1'b0;
  logic        sram_we;
  logic [14:0] sram_addr;
  logic        sram_wdata;
  logic [6:0]  fifo_count;
  logic        fifo_full;
  logic        fifo_empty;
  logic        overflow;
  logic        clip_drop;
  logic        idle;

  int total = 0;
  int bad = 0;

  // model state: each entry is {address[14:0], value}
  logic [15:0] exp_q[$];
  logic        exp_we = 1'b0;
  logic [14:0] exp_addr = 15'd0;
  logic        exp_wdata = 1'b0;
  logic        exp_ovf = 1'b0;
  logic        exp_clip = 1'b0;

  pixel_write_buffer #(.DEPTH(DEPTH), .H_RES(H_RES), .V_RES(V_RES)) dut (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .write_x_pos(write_x_pos),
    .write_y_pos(write_y_pos), .pixel_value(pixel_value), .sram_wr_grant(sram_wr_grant),
    .clear_overflow(clear_overflow), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .fifo_count(fifo_count), .fifo_full(fifo_full),
    .fifo_empty(fifo_empty), .overflow(overflow), .clip_drop(clip_drop), .idle(idle)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic bit in_range(input int x, input int y);
    if (CLIP) return (x < H_RES) && (y < V_RES);
    return 1'b1;
  endfunction

  task automatic drive(input bit v, input int x, input int y, input bit p, input bit g, input bit clr);
    wr_valid       = v;
    write_x_pos    = 8'(x);
    write_y_pos    = 7'(y);
    pixel_value    = p;
    sram_wr_grant  = g;
    clear_overflow = clr;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".we"},    sram_we,    exp_we);
    check({tag, ".addr"},  sram_addr,  exp_addr);
    check({tag, ".wdata"}, sram_wdata, exp_wdata);
    check({tag, ".count"}, fifo_count, exp_q.size());
    check({tag, ".full"},  fifo_full,  exp_q.size() == DEPTH);
    check({tag, ".empty"}, fifo_empty, exp_q.size() == 0);
    check({tag, ".ovf"},   overflow,   exp_ovf);
    check({tag, ".clip"},  clip_drop,  exp_clip);
    check({tag, ".idle"},  idle,       (exp_q.size() == 0) && !exp_we);
  endtask

  // one clock edge: model evaluates the buffer rules on the inputs seen at the edge
  task automatic tick(input string tag);
    bit          pop;
    bit          push_req;
    bit          accept;
    int          x;
    int          y;
    int          a;
    logic [15:0] ent;
    x        = int'(write_x_pos);
    y        = int'(write_y_pos);
    pop      = sram_wr_grant && (exp_q.size() > 0);
    push_req = wr_valid && in_range(x, y);
    accept   = push_req && ((exp_q.size() < DEPTH) || pop);
    a        = y * H_RES + x;
    @(posedge clk);
    if (pop) begin
      ent       = exp_q.pop_front();
      exp_addr  = ent[15:1];
      exp_wdata = ent[0];
    end
    exp_we = pop;
    if (accept) exp_q.push_back({a[14:0], pixel_value});
    if (push_req && !accept) exp_ovf = 1'b1;
    else if (clear_overflow) exp_ovf = 1'b0;
    exp_clip = wr_valid && !in_range(x, y);
    #1;
    check_all(tag);
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_we    = 1'b0;
    exp_addr  = 15'd0;
    exp_wdata = 1'b0;
    exp_ovf   = 1'b0;
    exp_clip  = 1'b0;
  endtask

  initial begin
    // reset state
    model_reset();
    #3;
    check_all("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // single pixel latency: (28,7) value 1 -> addr 1148
    drive(1, 28, 7, 1, 1, 0);
    tick("single0");
    check("single_we_edge0", sram_we, 0);
    drive(0, 0, 0, 0, 1, 0);
    tick("single1");
    check("single_we_edge1", sram_we, 1);
    check("single_addr", sram_addr, 1148);
    check("single_wdata", sram_wdata, 1);
    tick("single2");
    check("single_we_edge2", sram_we, 0);

    // corners
    drive(1, 159, 119, 1, 1, 0);
    tick("corner0");
    drive(1, 0, 0, 0, 1, 0);
    tick("corner1");
    check("corner_max_addr", sram_addr, 19199);
    drive(0, 0, 0, 0, 1, 0);
    tick("corner2");
    check("corner_zero_addr", sram_addr, 0);
    tick("corner3");

    // backpressure: 17 pushes with no grant, clear on the overflowing edge
    for (int i = 0; i < 17; i++) begin
      drive(1, $urandom_range(0, H_RES - 1), $urandom_range(0, V_RES - 1),
            1'($urandom_range(0, 1)), 0, i == 16);
      tick("bp_fill");
    end
    check("bp_full", fifo_full, 1);
    check("bp_count", fifo_count, 16);
    check("bp_ovf", overflow, 1);
    drive(0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 16; i++) begin
      tick("bp_drain");
      check("bp_drain_we", sram_we, 1);
    end
    drive(0, 0, 0, 0, 1, 0);
    tick("bp_after");
    check("bp_idle", idle, 1);

    // full with simultaneous push and pop
    for (int i = 0; i < 16; i++) begin
      drive(1, $urandom_range(0, H_RES - 1), $urandom_range(0, V_RES - 1),
            1'($urandom_range(0, 1)), 0, 0);
      tick("pp_fill");
    end
    drive(1, 77, 33, 1, 1, 0);
    tick("pp_both");
    check("pp_count", fifo_count, 16);
    check("pp_ovf", overflow, 0);
    drive(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 16; i++) tick("pp_drain");
    check("pp_last_addr", sram_addr, 33 * H_RES + 77);
    tick("pp_after");

    // out-of-range pixels
    drive(1, 160, 5, 1, 1, 0);
    tick("clip0");
    check("clip0_pulse", clip_drop, CLIP);
    drive(1, 3, 120, 1, 1, 0);
    tick("clip1");
    check("clip1_pulse", clip_drop, CLIP);
    check("clip1_we", sram_we, !CLIP);
    drive(0, 0, 0, 0, 1, 0);
    tick("clip2");
    check("clip2_we", sram_we, !CLIP);
    tick("clip3");

    // reset mid-drain
    for (int i = 0; i < 5; i++) begin
      drive(1, $urandom_range(0, H_RES - 1), $urandom_range(0, V_RES - 1), 1, 0, 0);
      tick("rst_fill");
    end
    drive(0, 0, 0, 0, 1, 0);
    tick("rst_drain");
    check("rst_drain_we", sram_we, 1);
    rst_n = 1'b0;
    model_reset();
    #2;
    check("rst_async_we", sram_we, 0);
    check("rst_async_count", fifo_count, 0);
    check_all("rst_async");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) tick("rst_quiet");

    // randomized traffic with alternating grant-starved phases
    for (int i = 0; i < 600; i++) begin
      int  x;
      int  y;
      bit  g;
      if ($urandom_range(0, 9) == 0) begin
        x = $urandom_range(0, 255);
        y = $urandom_range(0, 127);
      end else begin
        x = $urandom_range(0, H_RES - 1);
        y = $urandom_range(0, V_RES - 1);
      end
      if (((i / 60) % 2) == 1) g = ($urandom_range(0, 4) == 0);
      else                     g = ($urandom_range(0, 3) != 0);
      drive($urandom_range(0, 3) != 0, x, y, 1'($urandom_range(0, 1)), g,
            $urandom_range(0, 15) == 0);
      tick("rand");
    end
    drive(0, 0, 0, 0, 1, 1);
    for (int i = 0; i < DEPTH + 2; i++) tick("final_drain");
    check("final_idle", idle, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
